// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decode-stage control, register numbers, PC,
// operands and immediate for the execute stage, with flush (bubble) and stall (hold).
module id_ex_pipeline_reg #(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned ALUOP_W    = 2,
   parameter int unsigned FUNCT_W    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  stall,
   input  logic                  Branch,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic                  MemtoReg,
   input  logic                  RegWrite,
   input  logic                  ALUSrc,
   input  logic [ALUOP_W-1:0]    ALUOp,
   input  logic [FUNCT_W-1:0]    Funct,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   input  logic [REG_ADDR_W-1:0] rd,
   input  logic [DATA_W-1:0]     IFID_PC_Out,
   input  logic [DATA_W-1:0]     ReadData1,
   input  logic [DATA_W-1:0]     ReadData2,
   input  logic [DATA_W-1:0]     imm_data,
   output logic                  IDEX_Branch,
   output logic                  IDEX_MemRead,
   output logic                  IDEX_MemWrite,
   output logic                  IDEX_MemtoReg,
   output logic                  IDEX_RegWrite,
   output logic                  IDEX_ALUSrc,
   output logic [ALUOP_W-1:0]    IDEX_ALUOp,
   output logic [FUNCT_W-1:0]    IDEX_Funct,
   output logic [REG_ADDR_W-1:0] IDEX_rs1,
   output logic [REG_ADDR_W-1:0] IDEX_rs2,
   output logic [REG_ADDR_W-1:0] IDEX_rd,
   output logic [DATA_W-1:0]     IDEX_PC_Out,
   output logic [DATA_W-1:0]     IDEX_ReadData1,
   output logic [DATA_W-1:0]     IDEX_ReadData2,
   output logic [DATA_W-1:0]     imm_data1
);

   // Flush clears exactly like reset; the all-zero control word is the NOP bubble.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         IDEX_Branch    <= 1'b0;
         IDEX_MemRead   <= 1'b0;
         IDEX_MemWrite  <= 1'b0;
         IDEX_MemtoReg  <= 1'b0;
         IDEX_RegWrite  <= 1'b0;
         IDEX_ALUSrc    <= 1'b0;
         IDEX_ALUOp     <= '0;
         IDEX_Funct     <= '0;
         IDEX_rs1       <= '0;
         IDEX_rs2       <= '0;
         IDEX_rd        <= '0;
         IDEX_PC_Out    <= '0;
         IDEX_ReadData1 <= '0;
         IDEX_ReadData2 <= '0;
         imm_data1      <= '0;
      end else if (!stall) begin
         IDEX_Branch    <= Branch;
         IDEX_MemRead   <= MemRead;
         IDEX_MemWrite  <= MemWrite;
         IDEX_MemtoReg  <= MemtoReg;
         IDEX_RegWrite  <= RegWrite;
         IDEX_ALUSrc    <= ALUSrc;
         IDEX_ALUOp     <= ALUOp;
         IDEX_Funct     <= Funct;
         IDEX_rs1       <= rs1;
         IDEX_rs2       <= rs2;
         IDEX_rd        <= rd;
         IDEX_PC_Out    <= IFID_PC_Out;
         IDEX_ReadData1 <= ReadData1;
         IDEX_ReadData2 <= ReadData2;
         imm_data1      <= imm_data;
      end
   end

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for id_ex_pipeline_reg: reset, loads, stall hold, flush and
// reset priority, each checked field-by-field against hand-written vectors.
module tb_id_ex_pipeline_reg;

   localparam int unsigned DATA_W     = 64;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned ALUOP_W    = 2;
   localparam int unsigned FUNCT_W    = 4;

   typedef struct packed {
      logic                  br, mr, mw, m2r, rw, asrc;
      logic [ALUOP_W-1:0]    aluop;
      logic [FUNCT_W-1:0]    funct;
      logic [REG_ADDR_W-1:0] rs1, rs2, rd;
      logic [DATA_W-1:0]     pc, rd1, rd2, imm;
   } vec_t;

   logic clk = 1'b0;
   logic reset, flush, stall;
   logic Branch, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrc;
   logic [ALUOP_W-1:0] ALUOp;
   logic [FUNCT_W-1:0] Funct;
   logic [REG_ADDR_W-1:0] rs1, rs2, rd;
   logic [DATA_W-1:0] IFID_PC_Out, ReadData1, ReadData2, imm_data;
   logic IDEX_Branch, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_RegWrite, IDEX_ALUSrc;
   logic [ALUOP_W-1:0] IDEX_ALUOp;
   logic [FUNCT_W-1:0] IDEX_Funct;
   logic [REG_ADDR_W-1:0] IDEX_rs1, IDEX_rs2, IDEX_rd;
   logic [DATA_W-1:0] IDEX_PC_Out, IDEX_ReadData1, IDEX_ReadData2, imm_data1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_pipeline_reg #(
      .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .ALUOP_W(ALUOP_W), .FUNCT_W(FUNCT_W)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush), .stall(stall),
      .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .Funct(Funct),
      .rs1(rs1), .rs2(rs2), .rd(rd), .IFID_PC_Out(IFID_PC_Out),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .imm_data(imm_data),
      .IDEX_Branch(IDEX_Branch), .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite),
      .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_ALUSrc(IDEX_ALUSrc),
      .IDEX_ALUOp(IDEX_ALUOp), .IDEX_Funct(IDEX_Funct), .IDEX_rs1(IDEX_rs1),
      .IDEX_rs2(IDEX_rs2), .IDEX_rd(IDEX_rd), .IDEX_PC_Out(IDEX_PC_Out),
      .IDEX_ReadData1(IDEX_ReadData1), .IDEX_ReadData2(IDEX_ReadData2), .imm_data1(imm_data1)
   );

   task automatic chk(input string tag, input string fld, input logic [DATA_W-1:0] obs,
                      input logic [DATA_W-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
      end
   endtask

   task automatic expect_outs(input string tag, input vec_t e);
      chk(tag, "Branch",    64'(IDEX_Branch),    64'(e.br));
      chk(tag, "MemRead",   64'(IDEX_MemRead),   64'(e.mr));
      chk(tag, "MemWrite",  64'(IDEX_MemWrite),  64'(e.mw));
      chk(tag, "MemtoReg",  64'(IDEX_MemtoReg),  64'(e.m2r));
      chk(tag, "RegWrite",  64'(IDEX_RegWrite),  64'(e.rw));
      chk(tag, "ALUSrc",    64'(IDEX_ALUSrc),    64'(e.asrc));
      chk(tag, "ALUOp",     64'(IDEX_ALUOp),     64'(e.aluop));
      chk(tag, "Funct",     64'(IDEX_Funct),     64'(e.funct));
      chk(tag, "rs1",       64'(IDEX_rs1),       64'(e.rs1));
      chk(tag, "rs2",       64'(IDEX_rs2),       64'(e.rs2));
      chk(tag, "rd",        64'(IDEX_rd),        64'(e.rd));
      chk(tag, "PC",        IDEX_PC_Out,         e.pc);
      chk(tag, "ReadData1", IDEX_ReadData1,      e.rd1);
      chk(tag, "ReadData2", IDEX_ReadData2,      e.rd2);
      chk(tag, "imm",       imm_data1,           e.imm);
   endtask

   task automatic drive(input vec_t v);
      {Branch, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrc} = {v.br, v.mr, v.mw, v.m2r, v.rw, v.asrc};
      ALUOp = v.aluop;  Funct = v.funct;
      rs1 = v.rs1;  rs2 = v.rs2;  rd = v.rd;
      IFID_PC_Out = v.pc;  ReadData1 = v.rd1;  ReadData2 = v.rd2;  imm_data = v.imm;
   endtask

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t zero, v1, v2, v3, v4;
      zero = '0;
      v1 = '{br:1'b1, mr:1'b1, mw:1'b0, m2r:1'b1, rw:1'b1, asrc:1'b1, aluop:2'b10, funct:4'b1001,
             rs1:5'd1, rs2:5'd2, rd:5'd3, pc:64'd100, rd1:64'd200, rd2:64'd300, imm:64'd400};
      v2 = '{br:1'b0, mr:1'b0, mw:1'b1, m2r:1'b0, rw:1'b1, asrc:1'b0, aluop:2'b01, funct:4'b0010,
             rs1:5'd8, rs2:5'd9, rd:5'd10, pc:64'd500, rd1:64'd600, rd2:64'd700, imm:64'd800};
      v3 = '{br:1'b1, mr:1'b0, mw:1'b1, m2r:1'b1, rw:1'b0, asrc:1'b1, aluop:2'b11, funct:4'b0110,
             rs1:5'd31, rs2:5'd16, rd:5'd21, pc:64'hFFFF_0000_1234_5678,
             rd1:64'h8000_0000_0000_0001, rd2:64'hDEAD_BEEF_CAFE_F00D, imm:64'hFFFF_FFFF_FFFF_FFF0};
      v4 = '{br:1'b0, mr:1'b1, mw:1'b0, m2r:1'b0, rw:1'b1, asrc:1'b0, aluop:2'b00, funct:4'b1111,
             rs1:5'd5, rs2:5'd30, rd:5'd17, pc:64'h0000_0001_0000_0004,
             rd1:64'h7FFF_FFFF_FFFF_FFFF, rd2:64'h0123_4567_89AB_CDEF, imm:64'h0000_0000_0000_0800};

      reset = 1'b1;  flush = 1'b0;  stall = 1'b0;
      drive(zero);
      tick();
      expect_outs("reset_zero_in", zero);

      drive(v1);
      tick();
      expect_outs("reset_nonzero_in", zero);

      reset = 1'b0;
      #1;
      expect_outs("pre_load1", zero);
      tick();
      expect_outs("load1", v1);

      drive(v2);
      #1;
      expect_outs("pre_load2", v1);
      tick();
      expect_outs("load2", v2);

      stall = 1'b1;
      drive(v3);
      tick();
      expect_outs("stall_edge1", v2);
      drive(v4);
      tick();
      expect_outs("stall_edge2", v2);
      drive(v3);
      stall = 1'b0;
      tick();
      expect_outs("post_stall", v3);

      flush = 1'b1;
      drive(v4);
      tick();
      expect_outs("flush", zero);

      flush = 1'b0;
      tick();
      expect_outs("reload_v4", v4);
      flush = 1'b1;  stall = 1'b1;
      drive(v1);
      tick();
      expect_outs("flush_over_stall", zero);

      flush = 1'b0;  stall = 1'b0;
      drive(v2);
      tick();
      expect_outs("reload_v2", v2);
      reset = 1'b1;  stall = 1'b1;
      drive(v3);
      tick();
      expect_outs("reset_over_stall", zero);

      reset = 1'b0;  stall = 1'b0;
      tick();
      expect_outs("first_after_reset", v3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
